gb_cpu_bus_ctrl: RTL

Memory-bus sequencer for the gameboy CPU. It accepts one read or write request per M-cycle from the control unit and drives the external address/data bus across four T-states. For reads, it returns the fetched byte to the register file over the data-bus write port (`data_bus_req` / `data_bus_data` / `data_bus_wren`), which targets IR, TMP_L or TMP_H. It is the producing end of that port; the register file is the consuming end.

---
 rtl/gb_cpu_common_pkg.sv | 104 ++++++++++
 rtl/gb_cpu_bus_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: register file layout, register selectors and the
// bus-sequencer address/state enums with their helper functions.
package gb_cpu_common_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 16;

    typedef enum logic [3:0] {
        REG_B, REG_C, REG_D, REG_E, REG_H, REG_L, REG_A, REG_F,
        REG_IR, REG_TMP_L, REG_TMP_H, REG_SP_H, REG_SP_L, REG_PC_H, REG_PC_L
    } regfile_r8_t;

    typedef enum logic [2:0] {
        REG_BC, REG_DE, REG_HL, REG_AF, REG_SP, REG_PC, REG_TMP
    } regfile_r16_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] f;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] e;
        logic [DATA_W-1:0] h;
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] ir;
        logic [DATA_W-1:0] tmp_h;
        logic [DATA_W-1:0] tmp_l;
        logic [ADDR_W-1:0] sp;
        logic [ADDR_W-1:0] pc;
    } regfile_t;

    typedef enum logic [1:0] {
        ADDR_R16, ADDR_HIGH_TMP, ADDR_HIGH_C
    } bus_addr_mode_t;

    typedef enum logic [2:0] {
        BUS_IDLE, BUS_T1, BUS_T2, BUS_T3, BUS_T4
    } bus_state_t;

    function automatic logic [DATA_W-1:0] getRegisterHigh(regfile_t regs, regfile_r16_t sel);
        case (sel)
            REG_BC:  getRegisterHigh = regs.b;
            REG_DE:  getRegisterHigh = regs.d;
            REG_HL:  getRegisterHigh = regs.h;
            REG_AF:  getRegisterHigh = regs.a;
            REG_SP:  getRegisterHigh = regs.sp[15:8];
            REG_PC:  getRegisterHigh = regs.pc[15:8];
            REG_TMP: getRegisterHigh = regs.tmp_h;
            default: getRegisterHigh = 8'h00;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] getRegisterLow(regfile_t regs, regfile_r16_t sel);
        case (sel)
            REG_BC:  getRegisterLow = regs.c;
            REG_DE:  getRegisterLow = regs.e;
            REG_HL:  getRegisterLow = regs.l;
            REG_AF:  getRegisterLow = regs.f;
            REG_SP:  getRegisterLow = regs.sp[7:0];
            REG_PC:  getRegisterLow = regs.pc[7:0];
            REG_TMP: getRegisterLow = regs.tmp_l;
            default: getRegisterLow = 8'h00;
        endcase
    endfunction

    // High-page modes address the I/O window at 0xFF00; 0xFFFF is reachable.
    function automatic logic [ADDR_W-1:0] busAddr(regfile_t regs, bus_addr_mode_t mode,
                                                  regfile_r16_t sel);
        case (mode)
            ADDR_R16:      busAddr = {getRegisterHigh(regs, sel), getRegisterLow(regs, sel)};
            ADDR_HIGH_TMP: busAddr = {8'hFF, regs.tmp_l};
            ADDR_HIGH_C:   busAddr = {8'hFF, regs.c};
            default:       busAddr = 16'h0000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] readReg8(regfile_t regs, regfile_r8_t sel);
        case (sel)
            REG_B:     readReg8 = regs.b;
            REG_C:     readReg8 = regs.c;
            REG_D:     readReg8 = regs.d;
            REG_E:     readReg8 = regs.e;
            REG_H:     readReg8 = regs.h;
            REG_L:     readReg8 = regs.l;
            REG_A:     readReg8 = regs.a;
            REG_F:     readReg8 = regs.f;
            REG_IR:    readReg8 = regs.ir;
            REG_TMP_L: readReg8 = regs.tmp_l;
            REG_TMP_H: readReg8 = regs.tmp_h;
            REG_SP_H:  readReg8 = regs.sp[15:8];
            REG_SP_L:  readReg8 = regs.sp[7:0];
            REG_PC_H:  readReg8 = regs.pc[15:8];
            REG_PC_L:  readReg8 = regs.pc[7:0];
            default:   readReg8 = 8'h00;
        endcase
    endfunction

    // Only these targets are writable through the data-bus port.
    function automatic logic isDataBusDest(regfile_r8_t sel);
        isDataBusDest = (sel == REG_IR) || (sel == REG_TMP_L) || (sel == REG_TMP_H);
    endfunction

endpackage

// File: rtl/gb_cpu_bus_ctrl.sv
// Four-T-state memory bus sequencer: snapshots one request per M-cycle,
// drives the external bus and returns read bytes to the register file.
module gb_cpu_bus_ctrl
    import gb_cpu_common_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  regfile_t             registers,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  bus_addr_mode_t       req_addr_mode,
    input  regfile_r16_t         req_addr_reg,
    input  regfile_r8_t          req_wdata_reg,
    input  regfile_r8_t          req_dest,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 mem_rd,
    output logic                 mem_wr,
    input  logic                 mem_wait,
    input  logic [DATA_W-1:0]    mem_rdata,
    output regfile_r8_t          data_bus_req,
    output logic [DATA_W-1:0]    data_bus_data,
    output logic                 data_bus_wren,
    output logic                 done,
    output logic                 bus_err
);

    bus_state_t          r_state;
    bus_state_t          w_state_nxt;

    logic                r_write,      w_write_nxt;
    regfile_r8_t         r_dest,       w_dest_nxt;
    logic [DATA_W-1:0]   r_wbyte,      w_wbyte_nxt;

    logic                r_req_ready,  w_req_ready_nxt;
    logic [ADDR_W-1:0]   r_mem_addr,   w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata,  w_mem_wdata_nxt;
    logic                r_mem_rd,     w_mem_rd_nxt;
    logic                r_mem_wr,     w_mem_wr_nxt;
    regfile_r8_t         r_db_req,     w_db_req_nxt;
    logic [DATA_W-1:0]   r_db_data,    w_db_data_nxt;
    logic                r_db_wren,    w_db_wren_nxt;
    logic                r_done,       w_done_nxt;
    logic                r_bus_err,    w_bus_err_nxt;

    logic                w_accept;

    assign w_accept = req_valid && r_req_ready;

    // Next-state and next-output values; every output is registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_write_nxt     = r_write;
        w_dest_nxt      = r_dest;
        w_wbyte_nxt     = r_wbyte;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_rd_nxt    = 1'b0;
        w_mem_wr_nxt    = 1'b0;
        w_db_req_nxt    = r_db_req;
        w_db_data_nxt   = r_db_data;
        w_db_wren_nxt   = 1'b0;
        w_done_nxt      = 1'b0;
        w_bus_err_nxt   = 1'b0;

        case (r_state)
            BUS_IDLE, BUS_T4: begin
                if (w_accept) begin
                    w_state_nxt    = BUS_T1;
                    w_write_nxt    = req_write;
                    w_dest_nxt     = req_dest;
                    w_wbyte_nxt    = readReg8(registers, req_wdata_reg);
                    w_mem_addr_nxt = busAddr(registers, req_addr_mode, req_addr_reg);
                end else begin
                    w_state_nxt    = BUS_IDLE;
                end
            end
            BUS_T1: begin
                w_state_nxt  = BUS_T2;
                w_mem_rd_nxt = !r_write;
                w_mem_wr_nxt = r_write;
                if (r_write) begin
                    w_mem_wdata_nxt = r_wbyte;
                end
            end
            BUS_T2: begin
                w_state_nxt  = BUS_T3;
                w_mem_rd_nxt = !r_write;
                w_mem_wr_nxt = r_write;
            end
            BUS_T3: begin
                w_mem_rd_nxt = !r_write;
                w_mem_wr_nxt = r_write;
                if (!mem_wait) begin
                    w_state_nxt  = BUS_T4;
                    w_mem_rd_nxt = 1'b0;
                    w_mem_wr_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    if (!r_write) begin
                        w_db_data_nxt = mem_rdata;
                        if (isDataBusDest(r_dest)) begin
                            w_db_wren_nxt = 1'b1;
                            w_db_req_nxt  = r_dest;
                        end else begin
                            w_bus_err_nxt = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = BUS_IDLE;
            end
        endcase

        w_req_ready_nxt = (w_state_nxt == BUS_IDLE) || (w_state_nxt == BUS_T4);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= BUS_IDLE;
            r_write     <= 1'b0;
            r_dest      <= REG_IR;
            r_wbyte     <= 8'h00;
            r_req_ready <= 1'b1;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 8'h00;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_db_req    <= REG_IR;
            r_db_data   <= 8'h00;
            r_db_wren   <= 1'b0;
            r_done      <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_write     <= w_write_nxt;
            r_dest      <= w_dest_nxt;
            r_wbyte     <= w_wbyte_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_db_req    <= w_db_req_nxt;
            r_db_data   <= w_db_data_nxt;
            r_db_wren   <= w_db_wren_nxt;
            r_done      <= w_done_nxt;
            r_bus_err   <= w_bus_err_nxt;
        end
    end

    assign req_ready     = r_req_ready;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_rd        = r_mem_rd;
    assign mem_wr        = r_mem_wr;
    assign data_bus_req  = r_db_req;
    assign data_bus_data = r_db_data;
    assign data_bus_wren = r_db_wren;
    assign done          = r_done;
    assign bus_err       = r_bus_err;

endmodule
